demux1_4_buf: RTL and testbench
===============================

DEMUX1_4_BUF -- requirements
Module: demux1_4_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, the entries per output buffer; only the value 2 is supported.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset; asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning the input word is offered.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the block can accept the word for the selected port.
REQ-007 SHALL have port in_data, input, DATA_W bits, the input payload.
REQ-008 SHALL have port in_sel, input, 2 bits, the destination port index (0..3).
REQ-009 SHALL have port out_valid, output, 4 bits, where bit i means output i holds a word.
REQ-010 SHALL have port out_ready, input, 4 bits, where bit i means the consumer of output i accepts the word.
REQ-011 SHALL have ports out_data0, out_data1, out_data2 and out_data3, each an output of DATA_W bits carrying the head word of each port.

Function
REQ-012 SHALL accept an input word on a rising edge where in_valid && in_ready (input handshake).
REQ-013 SHALL sample in_sel only at the input handshake; in_sel has no effect in any other cycle.
REQ-014 SHALL drive in_ready = (count[in_sel] != 2), purely combinational from in_sel and the registered counts, with no path from out_ready.
REQ-015 SHALL keep an independent 2-entry FIFO with a count of 0..2 for each output port i.
REQ-016 SHALL make out_valid[i] = (count[i] != 0); out_data_i SHALL be the oldest word in FIFO i.
REQ-017 SHALL pop FIFO i on a rising edge where out_valid[i] && out_ready[i].
REQ-018 SHALL have a latency of 1 cycle: a word accepted at edge N is visible on out_data_i with out_valid[i] after edge N.
REQ-019 SHALL deliver words on each port in input acceptance order; there is no ordering guarantee across ports.
REQ-020 SHALL leave count[i] unchanged on a simultaneous push and pop of port i (count 1 or 2); the pushed word enters behind the current tail.
REQ-021 SHALL allow a push to a full port only if that port is not full at the start of the cycle, so simultaneous push and pop on a full port is not accepted.
REQ-022 SHALL have no effect when popping an empty port; out_valid[i] = 0 and count stays 0.
REQ-023 SHALL let pushes to port j proceed regardless of the state of port i != j; there is no head-of-line blocking beyond the current input word.
REQ-024 SHALL hold out_data_i stable while out_valid[i] && !out_ready[i].
REQ-025 SHALL wrap the FIFO read/write pointers (1 bit each) modulo 2.

Reset
REQ-026 SHALL, while rst = 1, asynchronously clear all counts and pointers to 0 and drive out_valid to 4'b0000.
REQ-027 SHALL keep in_ready = 1 during reset (all counts 0); words offered during reset are not accepted.
REQ-028 SHALL, on reset mid-operation, discard all buffered words; out_data_i content is don't-care after reset and out_data_i SHALL be 0 from the cleared storage.
REQ-029 SHALL allow the first handshake on the first rising edge after rst deasserts.

Structure
REQ-030 SHALL place DATA_W default, NPORT = 4, SEL_W = 2 and DEPTH = 2 constants in a shared package demux_pkg.
REQ-031 SHALL implement each port buffer as sub-module demux_fifo2 (push, pop, data in/out, full, empty, count), instantiated four times.
REQ-032 SHALL keep the top level to select decoding, push steering and ready generation only.

Verification
REQ-033 SHALL cover this scenario: after reset, push 0xAAAA0001 with sel=2 and out_ready=0 -> out_valid=4'b0100 and out_data2=0xAAAA0001 one cycle later.
REQ-034 SHALL cover this scenario: push 0x11 and then 0x22 to port 1 with out_ready=0 -> count 2, in_ready=0 for sel=1, in_ready=1 for sel=3; then raise out_ready[1] -> 0x11 then 0x22 in order.
REQ-035 SHALL cover this scenario: port 0 full, simultaneous pop of port 0 and offer to port 0 -> not accepted that cycle, accepted next cycle; count ends at 2.
REQ-036 SHALL cover this scenario: port 3 holding 1 word, simultaneous push 0x33 and pop -> count stays 1 and out_data3 = 0x33 next cycle.
REQ-037 SHALL cover this scenario: a round-robin burst of 8 words to sel 0..3 with random out_ready -> each port delivers exactly 2 words in order, with no loss or duplication.
REQ-038 SHALL cover this scenario: assert rst mid-burst with ports 0 and 2 holding data -> out_valid=0 immediately (asynchronously), and in_ready=1.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-4 buffered demultiplexer.
// Each output port owns a 2-entry FIFO, and the top level steers pushes into those FIFOs.
package demux_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int NPORT      = 4;
    localparam int SEL_W      = 2;
    localparam int DEF_DEPTH  = 2;

    // Wide enough to hold an occupancy of 0..DEF_DEPTH.
    localparam int CNT_W = $clog2(DEF_DEPTH + 1);

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic [NPORT-1:0] sel_decode(input sel_t sel);
        logic [NPORT-1:0] hit;
        hit      = '0;
        hit[sel] = 1'b1;
        return hit;
    endfunction

endpackage

// File: rtl/demux1_4_buf_if.sv
// Groups the producer and consumer handshake of the demux into one bundle.
// The master side drives the input word and the output ready signals. The slave side is the demux itself.
interface demux1_4_buf_if
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    sel_t               in_sel;
    logic [NPORT-1:0]   out_valid;
    logic [NPORT-1:0]   out_ready;
    logic [DATA_W-1:0]  out_data [NPORT];

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/demux_fifo2.sv
// Two-entry FIFO used as one output buffer of the demux.
// It uses 1-bit wrapping pointers and an explicit occupancy count, so that full and empty never need pointer comparison.
module demux_fifo2
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output cnt_t              count
);

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Full is judged on the count at the start of the cycle, so a pop in the same cycle does not open a slot.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: the storage is cleared along with the control state, so each head word reads as zero after reset rather than as stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking updates let the push and pop paths both read the pre-edge pointers and count.
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_push && !do_pop) begin
                count <= count + cnt_t'(1);
            end else if (do_pop && !do_push) begin
                count <= count - cnt_t'(1);
            end
        end
    end

    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_count_in_range    : assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);

endmodule

// File: rtl/demux1_4_buf.sv
// Buffered 1-to-4 demultiplexer: routes each accepted word to the 2-entry FIFO chosen by in_sel.
// Every output port drains on its own, so there is no head-of-line blocking between ports.
module demux1_4_buf
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  sel_t              in_sel,
    output logic [NPORT-1:0]  out_valid,
    input  logic [NPORT-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3
);

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    logic [NPORT-1:0]  sel_hit;
    logic [NPORT-1:0]  push;
    logic [NPORT-1:0]  pop;
    logic [NPORT-1:0]  full;
    logic [NPORT-1:0]  empty;
    cnt_t              count [NPORT];
    logic [DATA_W-1:0] head  [NPORT];

    assign sel_hit = sel_decode(in_sel);

    // Ready depends only on the registered count of the selected port, never on out_ready.
    assign in_ready  = (count[in_sel] != FULL_CNT);
    assign push      = {NPORT{in_valid}} & sel_hit & ~full;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    for (genvar i = 0; i < NPORT; i++) begin : g_port
        demux_fifo2 #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (in_data),
            .dout  (head[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .count (count[i])
        );
    end

    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];

    a_push_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(push));

endmodule

// File: tb/tb_demux1_4_buf.sv
// Directed bench for demux1_4_buf: reset, single push, ordering, full and simultaneous cases, burst, and mid-run reset.
module tb_demux1_4_buf;
    import demux_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    demux1_4_buf_if #(.DATA_W(32)) bus ();

    demux1_4_buf #(.DATA_W(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (bus.in_data),
        .in_sel    (bus.in_sel),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data0 (bus.out_data[0]),
        .out_data1 (bus.out_data[1]),
        .out_data2 (bus.out_data[2]),
        .out_data3 (bus.out_data[3])
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd1;
        bus.in_data   = 32'hDEAD_BEEF;
        bus.out_ready = 4'hF;
        repeat (2) @(negedge clk);
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++; $display("FAIL rst_valid: got %b want 0000", bus.out_valid);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_ready: got %b want 1", bus.in_ready);
        end
        total++;
        if (bus.out_data[1] !== 32'h0) begin
            bad++; $display("FAIL rst_data1: got %h want 0", bus.out_data[1]);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        cycle();
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++; $display("FAIL empty_pop: got %b want 0000", bus.out_valid);
        end
        bus.out_ready = 4'h0;
    endtask

    task automatic test_single();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd2;
        bus.in_data  = 32'hAAAA_0001;
        cycle();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 4'b0100) begin
            bad++; $display("FAIL single_valid: got %b want 0100", bus.out_valid);
        end
        total++;
        if (bus.out_data[2] !== 32'hAAAA_0001) begin
            bad++; $display("FAIL single_data: got %h want aaaa0001", bus.out_data[2]);
        end
        bus.out_ready = 4'b0100;
        cycle();
        bus.out_ready = 4'b0000;
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++; $display("FAIL single_drain: got %b want 0000", bus.out_valid);
        end
    endtask

    task automatic test_order();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd1;
        bus.in_data  = 32'h11;
        cycle();
        bus.in_data  = 32'h22;
        cycle();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 4'b0010) begin
            bad++; $display("FAIL order_valid: got %b want 0010", bus.out_valid);
        end
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL order_full_sel1: got %b want 0", bus.in_ready);
        end
        bus.in_sel = 2'd3;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL order_free_sel3: got %b want 1", bus.in_ready);
        end
        bus.out_ready = 4'b0010;
        #1;
        total++;
        if (bus.out_data[1] !== 32'h11) begin
            bad++; $display("FAIL order_first: got %h want 11", bus.out_data[1]);
        end
        cycle();
        total++;
        if (bus.out_valid[1] !== 1'b1 || bus.out_data[1] !== 32'h22) begin
            bad++; $display("FAIL order_second: got %b/%h want 1/22", bus.out_valid[1], bus.out_data[1]);
        end
        cycle();
        bus.out_ready = 4'b0000;
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++; $display("FAIL order_drain: got %b want 0000", bus.out_valid);
        end
    endtask

    task automatic test_full_simul();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd0;
        bus.in_data  = 32'hA0;
        cycle();
        bus.in_data  = 32'hA1;
        cycle();
        bus.in_data   = 32'hA2;
        bus.out_ready = 4'b0001;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL full_simul_ready: got %b want 0", bus.in_ready);
        end
        cycle();
        bus.out_ready = 4'b0000;
        total++;
        if (bus.out_data[0] !== 32'hA1) begin
            bad++; $display("FAIL full_simul_head: got %h want a1", bus.out_data[0]);
        end
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL full_retry_ready: got %b want 1", bus.in_ready);
        end
        cycle();
        bus.in_valid = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_data[0] !== 32'hA1) begin
            bad++; $display("FAIL full_count2: got ready=%b head=%h want 0/a1", bus.in_ready, bus.out_data[0]);
        end
        bus.out_ready = 4'b0001;
        cycle();
        total++;
        if (bus.out_data[0] !== 32'hA2) begin
            bad++; $display("FAIL full_tail: got %h want a2", bus.out_data[0]);
        end
        cycle();
        bus.out_ready = 4'b0000;
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++; $display("FAIL full_drain: got %b want 0000", bus.out_valid);
        end
    endtask

    task automatic test_push_pop();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd3;
        bus.in_data  = 32'h30;
        cycle();
        bus.in_data   = 32'h33;
        bus.out_ready = 4'b1000;
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_data[3] !== 32'h30) begin
            bad++; $display("FAIL pp_before: got ready=%b head=%h want 1/30", bus.in_ready, bus.out_data[3]);
        end
        cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        #1;
        total++;
        if (bus.out_valid !== 4'b1000 || bus.out_data[3] !== 32'h33) begin
            bad++; $display("FAIL pp_after: got %b/%h want 1000/33", bus.out_valid, bus.out_data[3]);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL pp_count1: got ready %b want 1", bus.in_ready);
        end
        bus.out_ready = 4'b1000;
        cycle();
        bus.out_ready = 4'b0000;
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++; $display("FAIL pp_drain: got %b want 0000", bus.out_valid);
        end
    endtask

    task automatic test_burst();
        logic [31:0] exp_q [4][$];
        logic [31:0] want;
        int          sent = 0;
        int          got [4] = '{0, 0, 0, 0};
        bit          done = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            bus.out_ready = (cyc > 150) ? 4'hF : 4'($urandom_range(0, 15));
            if (sent < 8) begin
                bus.in_valid = 1'b1;
                bus.in_sel   = 2'(sent % 4);
                bus.in_data  = 32'hB000_0000 + 32'(sent);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            for (int p = 0; p < 4; p++) begin
                if (bus.out_valid[p] && bus.out_ready[p]) begin
                    total++;
                    if (exp_q[p].size() == 0) begin
                        bad++; $display("FAIL burst_extra: port %0d delivered %h unexpectedly", p, bus.out_data[p]);
                    end else begin
                        want = exp_q[p].pop_front();
                        if (bus.out_data[p] !== want) begin
                            bad++; $display("FAIL burst_data: port %0d got %h want %h", p, bus.out_data[p], want);
                        end
                    end
                    got[p]++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q[bus.in_sel].push_back(bus.in_data);
                sent++;
            end
            cycle();
            done = (sent == 8) && (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
                   (exp_q[2].size() == 0) && (exp_q[3].size() == 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        total++;
        if (!done || sent != 8) begin
            bad++; $display("FAIL burst_complete: sent %0d of 8, pending left", sent);
        end
        for (int p = 0; p < 4; p++) begin
            total++;
            if (got[p] != 2) begin
                bad++; $display("FAIL burst_count: port %0d got %0d words want 2", p, got[p]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd0;
        bus.in_data  = 32'hC0;
        cycle();
        bus.in_sel   = 2'd2;
        bus.in_data  = 32'hC2;
        cycle();
        bus.in_valid = 1'b0;
        bus.in_sel   = 2'd0;
        total++;
        if (bus.out_valid !== 4'b0101) begin
            bad++; $display("FAIL mid_loaded: got %b want 0101", bus.out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 4'b0000 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_async: got valid=%b ready=%b want 0000/1", bus.out_valid, bus.in_ready);
        end
        total++;
        if (bus.out_data[0] !== 32'h0 || bus.out_data[2] !== 32'h0) begin
            bad++; $display("FAIL mid_cleared: got %h/%h want 0/0", bus.out_data[0], bus.out_data[2]);
        end
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd1;
        bus.in_data  = 32'h77;
        cycle();
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++; $display("FAIL mid_no_accept: got %b want 0000", bus.out_valid);
        end
        rst = 1'b0;
        bus.in_data = 32'h55;
        cycle();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 4'b0010 || bus.out_data[1] !== 32'h55) begin
            bad++; $display("FAIL first_after_rst: got %b/%h want 0010/55", bus.out_valid, bus.out_data[1]);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 4'h0;
        test_reset();
        test_single();
        test_order();
        test_full_simul();
        test_push_pop();
        test_burst();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
